// File: rtl/rx_burst_sched_pkg.sv
// Shared definitions for the receive burst scheduler and the capture side.
package rx_burst_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BURST = 2'd1,
    ST_GAP   = 2'd2
  } state_e;

  localparam int unsigned BURST_BITS     = 148;
  localparam int unsigned GAP_BITS       = 8;
  localparam int unsigned SLOTS_PER_HALF = 8;

  // Constants shared with frame capture.
  localparam logic [47:0] MAC_ADDR      = 48'h02_00_00_00_00_01;
  localparam int unsigned ETH_BUF_BYTES = (2 * SLOTS_PER_HALF * BURST_BITS) / 8;

endpackage

// File: rtl/rx_burst_sched_if.sv
// Capture/serializer-side signals of rx_burst_sched.
//   master: scheduler side (drives everything except frame_wr)
//   slave : capture/serializer side
interface rx_burst_sched_if;

  logic       frame_wr;
  logic       wr_half;
  logic [1:0] half_valid;
  logic [3:0] slot_idx;
  logic       load;
  logic       ff_en;
  logic [7:0] bit_cnt;
  logic       start;
  logic       need_data;
  logic       underrun;
  logic       overflow;

  modport master (
    input  frame_wr,
    output wr_half, half_valid, slot_idx, load, ff_en, bit_cnt,
           start, need_data, underrun, overflow
  );

  modport slave (
    output frame_wr,
    input  wr_half, half_valid, slot_idx, load, ff_en, bit_cnt,
           start, need_data, underrun, overflow
  );

endinterface

// File: rtl/rx_burst_sched_gap_timer.sv
// Inter-burst gap counter; gap is one bit longer when long_i is set.
//   ff_clk, rst_n : clock (negedge active), async active-low reset
//   run_i         : scheduler is in the gap
//   long_i        : current slot takes the long gap
//   last_o        : this is the final gap cycle
module gap_timer
  import rx_burst_sched_pkg::*;
#(
  parameter int unsigned GAP_LEN = GAP_BITS
) (
  input  logic ff_clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic long_i,
  output logic last_o
);

  localparam int unsigned CW = $clog2(GAP_LEN + 2);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    last_o = run_i && (cnt_q == (long_i ? CW'(GAP_LEN) : CW'(GAP_LEN - 1)));
    cnt_d  = (run_i && !last_o) ? cnt_q + CW'(1) : '0;
  end

  always_ff @(negedge ff_clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/rx_burst_sched.sv
// Receive burst-buffer scheduler: half-buffer bookkeeping and burst/gap
// sequencing toward the bit serializer.
//   ff_clk, rst_n : clock (negedge active), async active-low reset
//   bus           : frame_wr in; wr_half, half_valid, slot_idx, load, ff_en,
//                   bit_cnt, start, need_data, underrun, overflow out
module rx_burst_sched #(
  parameter int unsigned BURST_BITS     = rx_burst_sched_pkg::BURST_BITS,
  parameter int unsigned GAP_BITS       = rx_burst_sched_pkg::GAP_BITS,
  parameter int unsigned SLOTS_PER_HALF = rx_burst_sched_pkg::SLOTS_PER_HALF
) (
  input  logic                     ff_clk,
  input  logic                     rst_n,
  rx_burst_sched_if.master         bus
);

  import rx_burst_sched_pkg::state_e;
  import rx_burst_sched_pkg::ST_IDLE;
  import rx_burst_sched_pkg::ST_BURST;
  import rx_burst_sched_pkg::ST_GAP;

  state_e     state_q, state_d;
  logic [7:0] bit_cnt_q, bit_cnt_d;
  logic [3:0] slot_q, slot_d;
  logic [1:0] hv_q, hv_d;
  logic       start_q, start_d;
  logic       und_q, und_d;
  logic       ovf_q, ovf_d;

  logic       rd_half, wr_half, burst_load, burst_end;
  logic       gap_run, gap_long, gap_last;
  logic [3:0] slot_inc;

  assign rd_half    = slot_q[3];
  // Point capture away from the read half while that half is still valid.
  assign wr_half    = hv_q[rd_half] ? ~rd_half : rd_half;
  assign slot_inc   = slot_q + 4'd1;
  assign burst_load = (state_q == ST_BURST) && (bit_cnt_q == '0);
  assign burst_end  = (state_q == ST_BURST) && (bit_cnt_q == 8'(BURST_BITS - 1));
  assign gap_run    = (state_q == ST_GAP);
  assign gap_long   = (slot_q[1:0] == 2'd3);

  gap_timer #(
    .GAP_LEN (GAP_BITS)
  ) u_gap_timer (
    .ff_clk (ff_clk),
    .rst_n  (rst_n),
    .run_i  (gap_run),
    .long_i (gap_long),
    .last_o (gap_last)
  );

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = '0;
    slot_d    = slot_q;
    hv_d      = hv_q;
    und_d     = 1'b0;
    ovf_d     = 1'b0;
    start_d   = start_q | burst_load;

    case (state_q)
      ST_IDLE: begin
        if (hv_q[rd_half]) state_d = ST_BURST;
      end
      ST_BURST: begin
        if (burst_end) begin
          state_d = ST_GAP;
          if (slot_q[2:0] == 3'(SLOTS_PER_HALF - 1)) hv_d[rd_half] = 1'b0;
        end else begin
          bit_cnt_d = bit_cnt_q + 8'd1;
        end
      end
      ST_GAP: begin
        if (gap_last) begin
          slot_d = slot_inc;
          if (hv_q[slot_inc[3]]) begin
            state_d = ST_BURST;
          end else begin
            state_d = ST_IDLE;
            und_d   = 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Never collides with the clear above: wr_half avoids a valid read half.
    if (bus.frame_wr) begin
      if (&hv_q) ovf_d = 1'b1;
      else       hv_d[wr_half] = 1'b1;
    end
  end

  always_ff @(negedge ff_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      bit_cnt_q <= '0;
      slot_q    <= '0;
      hv_q      <= '0;
      start_q   <= 1'b0;
      und_q     <= 1'b0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      slot_q    <= slot_d;
      hv_q      <= hv_d;
      start_q   <= start_d;
      und_q     <= und_d;
      ovf_q     <= ovf_d;
    end
  end

  assign bus.wr_half    = wr_half;
  assign bus.half_valid = hv_q;
  assign bus.slot_idx   = slot_q;
  assign bus.load       = burst_load;
  assign bus.ff_en      = (state_q == ST_BURST);
  assign bus.bit_cnt    = bit_cnt_q;
  assign bus.start      = start_q;
  assign bus.need_data  = (state_q != ST_IDLE) &&
                          ((slot_q[2:0] == 3'd3) || (slot_q[2:0] == 3'd4));
  assign bus.underrun   = und_q;
  assign bus.overflow   = ovf_q;

endmodule

// File: tb/tb_rx_burst_sched.sv
// Randomized bench for rx_burst_sched against a slot/period-level model.
module tb_rx_burst_sched;

  logic ff_clk = 1'b0;
  logic rst_n;

  always #5 ff_clk = ~ff_clk;

  rx_burst_sched_if bus ();

  rx_burst_sched #(
    .BURST_BITS     (148),
    .GAP_BITS       (8),
    .SLOTS_PER_HALF (8)
  ) dut (
    .ff_clk (ff_clk),
    .rst_n  (rst_n),
    .bus    (bus)
  );

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: "running" plus a position within the current slot
  // period (burst bits followed by the gap).
  bit       m_run;
  int       m_t;
  int       m_slot;
  bit [1:0] m_hv;
  bit       m_start, m_und, m_ovf;

  function automatic bit m_wr_half();
    int rh = m_slot / 8;
    return m_hv[rh] ? (rh == 0) : (rh == 1);
  endfunction

  task automatic model_reset();
    m_run = 0; m_t = 0; m_slot = 0; m_hv = 2'b00;
    m_start = 0; m_und = 0; m_ovf = 0;
  endtask

  task automatic model_step(input bit fw);
    bit [1:0] nhv = m_hv;
    int  rh  = m_slot / 8;
    bit  wh  = m_wr_half();
    bit  ld  = m_run && (m_t == 0);
    int  per = 148 + 8 + ((m_slot % 4 == 3) ? 1 : 0);
    m_und = 0;
    m_ovf = 0;
    if (m_run && m_t == 147 && m_slot % 8 == 7) nhv[rh] = 1'b0;
    if (fw) begin
      if (m_hv == 2'b11) m_ovf = 1;
      else nhv[wh] = 1'b1;
    end
    if (!m_run) begin
      if (m_hv[rh]) begin m_run = 1; m_t = 0; end
    end else if (m_t == per - 1) begin
      m_slot = (m_slot + 1) % 16;
      m_t = 0;
      if (!m_hv[m_slot / 8]) begin m_run = 0; m_und = 1; end
    end else begin
      m_t++;
    end
    m_start = m_start | ld;
    m_hv = nhv;
  endtask

  task automatic check_all();
    bit en = m_run && (m_t < 148);
    bit nd = m_run && ((m_slot % 8 == 3) || (m_slot % 8 == 4));
    check("wr_half",    bus.wr_half,    m_wr_half());
    check("half_valid", bus.half_valid, m_hv);
    check("slot_idx",   bus.slot_idx,   m_slot);
    check("load",       bus.load,       m_run && (m_t == 0));
    check("ff_en",      bus.ff_en,      en);
    check("bit_cnt",    bus.bit_cnt,    en ? m_t : 0);
    check("start",      bus.start,      m_start);
    check("need_data",  bus.need_data,  nd);
    check("underrun",   bus.underrun,   m_und);
    check("overflow",   bus.overflow,   m_ovf);
  endtask

  int cyc;
  int n_und, n_ovf;
  int ld_cyc[$];

  task automatic clear_stats();
    cyc = 0; n_und = 0; n_ovf = 0;
    ld_cyc.delete();
  endtask

  // One clock: drive frame_wr, step DUT and model on the active negedge,
  // compare on the following posedge.
  task automatic tick(input bit fw);
    bus.frame_wr = fw;
    @(negedge ff_clk);
    model_step(fw);
    @(posedge ff_clk);
    cyc++;
    check_all();
    if (bus.load)     ld_cyc.push_back(cyc);
    if (bus.underrun) n_und++;
    if (bus.overflow) n_ovf++;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus.frame_wr = 1'b0;
    model_reset();
    repeat (3) @(posedge ff_clk);
    check_all();
    rst_n = 1'b1;
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int i;
    rst_n = 1'b0;
    bus.frame_wr = 1'b0;
    model_reset();
    do_reset();

    // Single frame: eight bursts of half 0, then underrun into IDLE at slot 8.
    check("wr_half_pre", bus.wr_half, 0);
    clear_stats();
    tick(1'b1);
    for (int k = 0; k < 1400; k++) tick(1'b0);
    check("n_loads", ld_cyc.size(), 8);
    if (ld_cyc.size() >= 5) begin
      check("first_load_lat", ld_cyc[0], 2);
      check("period_s0", ld_cyc[1] - ld_cyc[0], 156);
      check("period_s3", ld_cyc[4] - ld_cyc[3], 157);
      check("four_bursts", ld_cyc[4] - ld_cyc[0], 625);
    end
    check("n_underrun_1", n_und, 1);
    check("idle_slot", bus.slot_idx, 8);
    check("idle_hv", bus.half_valid, 0);

    // Continuous supply across the half boundary, plus one overflow.
    clear_stats();
    tick(1'b1);
    for (i = 0; i < 2000 && m_slot != 10; i++) tick(1'b0);
    check("reach_slot10", m_slot, 10);
    tick(1'b1);
    check("hv_full", bus.half_valid, 2'b11);
    tick(1'b1);
    for (i = 0; i < 3000 && !(m_slot == 1); i++) tick(1'b0);
    check("wrap_to_slot1", bus.slot_idx, 1);
    check("n_underrun_0", n_und, 0);
    check("n_overflow_1", n_ovf, 1);
    for (int k = 0; k < 1400; k++) tick(1'b0);

    // Randomized frame arrivals.
    for (int k = 0; k < 8000; k++) tick($urandom_range(0, 299) == 0);

    // Reset in the middle of slot 5, then restart from slot 0.
    do_reset();
    tick(1'b1);
    for (i = 0; i < 2000 && !(m_run && m_slot == 5 && m_t == 70); i++) tick(1'b0);
    check("reach_s5_b70", bus.bit_cnt, 70);
    #2 rst_n = 1'b0;
    #1 model_reset();
    check_all();
    repeat (2) @(posedge ff_clk);
    check_all();
    rst_n = 1'b1;
    tick(1'b1);
    tick(1'b0);
    check("restart_slot", bus.slot_idx, 0);
    check("restart_load", bus.load, 1);
    for (int k = 0; k < 400; k++) tick(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
